// File: rtl/serial_parity_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parity_checker_if
//  Description : Frame-level signal bundle between a serial bit source
//                (master) and the serial parity checker (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 busy;
    logic                 done;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data_out;

    // Bit source: issues frame start and serial bits, observes results
    modport master (
        output start, bit_in, bit_valid,
        input  busy, done, parity_err, data_out
    );

    // Checker: consumes the serial stream, reports the frame result
    modport slave (
        input  start, bit_in, bit_valid,
        output busy, done, parity_err, data_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parity_checker
//  Description : Deserializes a frame of DATA_BITS data bits (LSB first)
//                followed by one parity bit, accumulating running parity in
//                a registered XOR. Reports the data word and a parity-error
//                flag alongside a one-cycle done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_parity_checker_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PAR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_acc;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_parity_err;
    logic [DATA_BITS-1:0] r_data;

    // Frame FSM: every output is a register so downstream sees glitch-free values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_acc        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_parity_err <= 1'b0;
            r_data       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // bit_valid is deliberately not looked at here, even on the start edge
                    if (bus.start) begin
                        r_state      <= ST_RECV;
                        r_cnt        <= '0;
                        r_acc        <= 1'b0;
                        r_data       <= '0;
                        r_parity_err <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (bus.bit_valid) begin
                        r_acc         <= r_acc ^ bus.bit_in;
                        r_data[r_cnt] <= bus.bit_in;
                        if (r_cnt == c_last_bit) begin
                            r_cnt   <= '0;
                            r_state <= ST_PAR;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    // Parity bit folds into the accumulator; the polarity picks even/odd
                    if (bus.bit_valid) begin
                        r_parity_err <= r_acc ^ bus.bit_in ^ ODD_PARITY;
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.parity_err = r_parity_err;
    assign bus.data_out   = r_data;

endmodule
`default_nettype wire
